rf_write_arbiter: RTL and testbench

Shares the register file's single write port between two writeback sources: port 0 (ALU writeback) and port 1 (load/store writeback).
- Each source uses a valid/ready handshake; arbitration is round-robin.
- The accepted write is registered and then driven onto the register file write port (RW_RF/DW_RF/WE_RF).
- Writes to x0 are suppressed.
- Forwarding flags tell the read stage when the staged write targets a register currently being read, because that value is not yet in the array.

---
 rtl/rf_write_arbiter.sv | 91 +++++++++
 tb/tb_rf_write_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU (port 0)
// and load/store (port 1) writeback, with a staged write and forwarding flags.
module rf_write_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic          V0_WB,
  input  logic [AW-1:0] A0_WB,
  input  logic [DW-1:0] D0_WB,
  output logic          R0_WB,
  input  logic          V1_WB,
  input  logic [AW-1:0] A1_WB,
  input  logic [DW-1:0] D1_WB,
  output logic          R1_WB,
  input  logic [AW-1:0] RA_RF,
  input  logic [AW-1:0] RB_RF,
  output logic [AW-1:0] RW_RF,
  output logic [DW-1:0] DW_RF,
  output logic          WE_RF,
  output logic          FWD_A,
  output logic          FWD_B,
  output logic          PRI
);

  logic          pri_q, pri_d;
  logic [AW-1:0] rw_q, rw_d;
  logic [DW-1:0] dw_q, dw_d;
  logic          we_q, we_d;
  logic          gnt0, gnt1;

  // Ready doubles as grant; held low during reset so nothing is accepted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!RES) begin
      if (V0_WB && V1_WB) begin
        gnt0 = !pri_q;
        gnt1 = pri_q;
      end else begin
        gnt0 = V0_WB;
        gnt1 = V1_WB;
      end
    end
  end

  always_comb begin
    pri_d = pri_q;
    rw_d  = rw_q;
    dw_d  = dw_q;
    we_d  = 1'b0;
    if (gnt0) begin
      pri_d = 1'b1;
      rw_d  = A0_WB;
      dw_d  = D0_WB;
      we_d  = (A0_WB != '0);
    end else if (gnt1) begin
      pri_d = 1'b0;
      rw_d  = A1_WB;
      dw_d  = D1_WB;
      we_d  = (A1_WB != '0);
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      pri_q <= 1'b0;
      rw_q  <= '0;
      dw_q  <= '0;
      we_q  <= 1'b0;
    end else begin
      pri_q <= pri_d;
      rw_q  <= rw_d;
      dw_q  <= dw_d;
      we_q  <= we_d;
    end
  end

  // The staged write is not yet in the array, so readers of that register must bypass.
  assign FWD_A = we_q && (rw_q == RA_RF) && (RA_RF != '0);
  assign FWD_B = we_q && (rw_q == RB_RF) && (RB_RF != '0);

  assign R0_WB = gnt0;
  assign R1_WB = gnt1;
  assign RW_RF = rw_q;
  assign DW_RF = dw_q;
  assign WE_RF = we_q;
  assign PRI   = pri_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios followed by a
// randomized stress run against a behavioural model of arbitration and commits.
module tb_rf_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          CLK = 1'b0;
  logic          RES;
  logic          V0_WB, V1_WB;
  logic [AW-1:0] A0_WB, A1_WB;
  logic [DW-1:0] D0_WB, D1_WB;
  logic          R0_WB, R1_WB;
  logic [AW-1:0] RA_RF, RB_RF;
  logic [AW-1:0] RW_RF;
  logic [DW-1:0] DW_RF;
  logic          WE_RF, FWD_A, FWD_B, PRI;

  int n_checks = 0;
  int n_fail   = 0;

  // Register file images: one fed by the DUT write port, one by the model.
  logic [DW-1:0] rf_dut   [2**AW];
  logic [DW-1:0] rf_model [2**AW];
  logic          rf_track = 1'b0;
  wr_t           exp_q[$];

  rf_write_arbiter #(.DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RES(RES),
    .V0_WB(V0_WB), .A0_WB(A0_WB), .D0_WB(D0_WB), .R0_WB(R0_WB),
    .V1_WB(V1_WB), .A1_WB(A1_WB), .D1_WB(D1_WB), .R1_WB(R1_WB),
    .RA_RF(RA_RF), .RB_RF(RB_RF),
    .RW_RF(RW_RF), .DW_RF(DW_RF), .WE_RF(WE_RF),
    .FWD_A(FWD_A), .FWD_B(FWD_B), .PRI(PRI)
  );

  always #5 CLK = ~CLK;

  // The array commits the staged write at the edge after WE_RF rises.
  always @(posedge CLK) begin
    if (rf_track && WE_RF) rf_dut[RW_RF] <= DW_RF;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    V0_WB = v0; A0_WB = a0; D0_WB = d0;
    V1_WB = v1; A1_WB = a1; D1_WB = d1;
  endtask

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic          p0, p1, g0, g1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    int            w0, w1;
    logic          m_turn, m_we;
    logic [AW-1:0] m_rw;
    logic [DW-1:0] m_dw;
    wr_t           got;

    for (int i = 0; i < 2**AW; i++) begin
      rf_dut[i]   = '0;
      rf_model[i] = '0;
    end

    // Reset with both requesters valid: no ready may be raised.
    RES = 1'b0;
    RA_RF = '0; RB_RF = '0;
    applyStimulus(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4);
    #1 RES = 1'b1;
    #11;
    checkOutput("reset_r0", 64'(R0_WB), 64'd0);
    checkOutput("reset_r1", 64'(R1_WB), 64'd0);
    checkOutput("reset_we", 64'(WE_RF), 64'd0);
    checkOutput("reset_rw", 64'(RW_RF), 64'd0);
    checkOutput("reset_dw", 64'(DW_RF), 64'd0);
    checkOutput("reset_pri", 64'(PRI), 64'd0);
    checkOutput("reset_fwd", 64'({FWD_A, FWD_B}), 64'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge CLK);
    RES = 1'b0;
    cycle();

    // Single port 0 write.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    #1;
    checkOutput("single_r0", 64'(R0_WB), 64'd1);
    checkOutput("single_r1", 64'(R1_WB), 64'd0);
    cycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("single_rw", 64'(RW_RF), 64'd5);
    checkOutput("single_dw", 64'(DW_RF), 64'hDEADBEEF);
    checkOutput("single_we", 64'(WE_RF), 64'd1);
    checkOutput("single_pri", 64'(PRI), 64'd1);
    cycle();
    checkOutput("single_we_drop", 64'(WE_RF), 64'd0);
    checkOutput("single_pri_hold", 64'(PRI), 64'd1);

    // x0 write on port 1: accepted, but never enabled or forwarded.
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234);
    RA_RF = '0;
    #1;
    checkOutput("x0_r1", 64'(R1_WB), 64'd1);
    checkOutput("x0_r0", 64'(R0_WB), 64'd0);
    cycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("x0_pri", 64'(PRI), 64'd0);
    checkOutput("x0_we", 64'(WE_RF), 64'd0);
    checkOutput("x0_rw", 64'(RW_RF), 64'd0);
    checkOutput("x0_fwd_a", 64'(FWD_A), 64'd0);

    // Forwarding on the staged write.
    applyStimulus(1'b1, 5'd7, 32'hCAFE0001, 1'b0, '0, '0);
    cycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    RA_RF = 5'd7; RB_RF = 5'd7;
    #1;
    checkOutput("fwd_we", 64'(WE_RF), 64'd1);
    checkOutput("fwd_dw", 64'(DW_RF), 64'hCAFE0001);
    checkOutput("fwd_a_hit", 64'(FWD_A), 64'd1);
    checkOutput("fwd_b_hit", 64'(FWD_B), 64'd1);
    RA_RF = 5'd8;
    #1;
    checkOutput("fwd_a_miss", 64'(FWD_A), 64'd0);
    checkOutput("fwd_b_still", 64'(FWD_B), 64'd1);

    // Asynchronous reset while a write is staged and a request is pending.
    applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, '0, '0);
    RES = 1'b1;
    #1;
    checkOutput("midrst_we", 64'(WE_RF), 64'd0);
    checkOutput("midrst_rw", 64'(RW_RF), 64'd0);
    checkOutput("midrst_dw", 64'(DW_RF), 64'd0);
    checkOutput("midrst_pri", 64'(PRI), 64'd0);
    checkOutput("midrst_fwd_b", 64'(FWD_B), 64'd0);
    checkOutput("midrst_r0", 64'(R0_WB), 64'd0);

    // Contention from PRI=0: grants must alternate 0,1,0,1.
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    RA_RF = '0; RB_RF = '0;
    @(negedge CLK);
    RES = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("cont_r0_%0d", k), 64'(R0_WB), 64'(k % 2 == 0));
      checkOutput($sformatf("cont_r1_%0d", k), 64'(R1_WB), 64'(k % 2 == 1));
      cycle();
      checkOutput($sformatf("cont_we_%0d", k), 64'(WE_RF), 64'd1);
      checkOutput($sformatf("cont_rw_%0d", k), 64'(RW_RF), (k % 2 == 0) ? 64'd1 : 64'd2);
      checkOutput($sformatf("cont_dw_%0d", k), 64'(DW_RF), (k % 2 == 0) ? 64'h11 : 64'h22);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    cycle();
    checkOutput("cont_we_end", 64'(WE_RF), 64'd0);
    checkOutput("cont_pri_end", 64'(PRI), 64'd0);

    // Random stress. Model state: whose turn it is on a tie, and the staged write.
    $display("[TB] starting random stress");
    rf_track = 1'b1;
    m_turn = 1'b0; m_we = 1'b0; m_rw = 5'd2; m_dw = 32'h22;
    p0 = 1'b0; p1 = 1'b0; w0 = 0; w1 = 0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (!p0 && $urandom_range(0, 9) < 6) begin
        p0 = 1'b1;
        a0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        d0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 9) < 6) begin
        p1 = 1'b1;
        a1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        d1 = $urandom;
      end
      applyStimulus(p0, a0, d0, p1, a1, d1);
      RA_RF = $urandom_range(0, 1) ? m_rw : 5'($urandom_range(0, 31));
      RB_RF = $urandom_range(0, 1) ? m_rw : 5'($urandom_range(0, 31));
      #1;
      g0 = p0 && (!p1 || m_turn == 1'b0);
      g1 = p1 && (!p0 || m_turn == 1'b1);
      checkOutput("st_r0", 64'(R0_WB), 64'(g0));
      checkOutput("st_r1", 64'(R1_WB), 64'(g1));
      checkOutput("st_pri", 64'(PRI), 64'(m_turn));
      checkOutput("st_fwd_a", 64'(FWD_A), 64'(m_we && m_rw == RA_RF && RA_RF != 0));
      checkOutput("st_fwd_b", 64'(FWD_B), 64'(m_we && m_rw == RB_RF && RB_RF != 0));
      if (p0 && !R0_WB) w0++;
      if (p1 && !R1_WB) w1++;
      checkOutput("st_wait0", 64'(w0 <= 1), 64'd1);
      checkOutput("st_wait1", 64'(w1 <= 1), 64'd1);
      m_we = 1'b0;
      if (g0 || g1) begin
        m_rw   = g0 ? a0 : a1;
        m_dw   = g0 ? d0 : d1;
        m_we   = (m_rw != 0);
        m_turn = g0;
        if (m_we) begin
          exp_q.push_back('{addr: m_rw, data: m_dw});
          rf_model[m_rw] = m_dw;
        end
        if (g0) begin p0 = 1'b0; w0 = 0; end
        else    begin p1 = 1'b0; w1 = 0; end
      end
      cycle();
      checkOutput("st_we", 64'(WE_RF), 64'(m_we));
      checkOutput("st_rw", 64'(RW_RF), 64'(m_rw));
      checkOutput("st_dw", 64'(DW_RF), 64'(m_dw));
      if (WE_RF) begin
        checkOutput("st_commit_pending", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          got = exp_q.pop_front();
          checkOutput("st_commit_addr", 64'(RW_RF), 64'(got.addr));
          checkOutput("st_commit_data", 64'(DW_RF), 64'(got.data));
        end
      end
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    cycle();
    cycle();
    checkOutput("st_queue_empty", 64'(exp_q.size()), 64'd0);
    for (int r = 1; r < 2**AW; r++) begin
      checkOutput($sformatf("st_rf_x%0d", r), 64'(rf_dut[r]), 64'(rf_model[r]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
